// File: rtl/trigger_capture.sv
// trigger_capture: CHANNELS-wide circular capture with pre-trigger, edge/auto trigger; `define TRIG_HYST_EN adds trig_hyst
module trigger_capture #(
    parameter int DATA_WIDTH   = 12,
    parameter int DEPTH        = 512,
    parameter int CHANNELS     = 2,
    parameter int PRE_TRIG     = 128,
    parameter int AUTO_TIMEOUT = 4096
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           sample_valid,
    input  logic [CHANNELS*DATA_WIDTH-1:0] sample_data,
    input  logic                           arm,
    input  logic                           auto_mode,
    input  logic                           trig_edge,
    input  logic [1:0]                     trig_ch,
    input  logic [DATA_WIDTH-1:0]          trig_level,
`ifdef TRIG_HYST_EN
    input  logic [DATA_WIDTH-1:0]          trig_hyst,
`endif
    input  logic [1:0]                     rd_ch,
    input  logic [$clog2(DEPTH)-1:0]       rd_addr,
    output logic [DATA_WIDTH-1:0]          rd_data,
    output logic                           busy,
    output logic                           done,
    output logic                           auto_fired
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(AUTO_TIMEOUT + 1);
    localparam logic [AW-1:0] PRE_C     = AW'(PRE_TRIG);
    localparam logic [AW-1:0] PRE_LAST  = AW'(PRE_TRIG - 1);
    localparam logic [AW:0]   POST_LAST = (AW+1)'(DEPTH - PRE_TRIG - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(AUTO_TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, PRETRIG, ARMED, POST, DONE} state_t;
    state_t state;

    logic [AW-1:0] wr_ptr, trig_ptr, pre_cnt, phys;
    logic [AW:0] post_cnt;
    logic [TW-1:0] timeout_cnt;
    logic [DATA_WIDTH-1:0] prev, cur, hyst, lo, hi;
    logic [DATA_WIDTH:0] sum;
    logic prev_valid, wr_en, trig_ok, edge_hit, timeout_hit;
    logic [DATA_WIDTH-1:0] ch_in [4];
    logic [DATA_WIDTH-1:0] ch_rd [4];

`ifdef TRIG_HYST_EN
    assign hyst = trig_hyst;
`else
    assign hyst = '0;
`endif

    assign wr_en       = sample_valid && ((state == PRETRIG && pre_cnt != PRE_C) || state == ARMED || state == POST);
    assign phys        = trig_ptr - PRE_C + rd_addr;
    assign cur         = ch_in[trig_ch];
    assign trig_ok     = 32'(trig_ch) < CHANNELS;
    assign lo          = trig_level > hyst ? trig_level - hyst : '0;
    assign sum         = {1'b0, trig_level} + {1'b0, hyst};
    assign hi          = sum[DATA_WIDTH] ? '1 : sum[DATA_WIDTH-1:0];
    assign edge_hit    = prev_valid && trig_ok &&
                         (trig_edge ? (prev > hi && cur <= trig_level) : (prev < lo && cur >= trig_level));
    assign timeout_hit = auto_mode && timeout_cnt == TO_LAST;

    // Unused channel slots read back and compare as zero.
    for (genvar c = 0; c < 4; c++) begin : g_ch
        if (c < CHANNELS) begin : g_mem
            logic [DATA_WIDTH-1:0] mem [DEPTH];
            always_ff @(posedge clk)
                if (wr_en) mem[wr_ptr] <= sample_data[c*DATA_WIDTH +: DATA_WIDTH];
            assign ch_in[c] = sample_data[c*DATA_WIDTH +: DATA_WIDTH];
            assign ch_rd[c] = mem[phys];
        end else begin : g_nil
            assign ch_in[c] = '0;
            assign ch_rd[c] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            trig_ptr    <= '0;
            pre_cnt     <= '0;
            post_cnt    <= '0;
            timeout_cnt <= '0;
            prev        <= '0;
            prev_valid  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            auto_fired  <= 1'b0;
            rd_data     <= '0;
        end else begin
            rd_data <= ch_rd[rd_ch];
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
                prev   <= cur;
            end
            case (state)
                IDLE, DONE: if (arm || (state == DONE && auto_mode)) begin
                    state      <= PRETRIG;
                    busy       <= 1'b1;
                    done       <= 1'b0;
                    pre_cnt    <= '0;
                    prev_valid <= 1'b0;
                    auto_fired <= 1'b0;
                end
                PRETRIG: begin
                    if (sample_valid && pre_cnt != PRE_C) pre_cnt <= pre_cnt + AW'(1);
                    if (pre_cnt == PRE_C || (sample_valid && pre_cnt == PRE_LAST)) begin
                        state       <= ARMED;
                        timeout_cnt <= '0;
                    end
                end
                ARMED: if (sample_valid) begin
                    prev_valid <= 1'b1;
                    if (timeout_cnt != TO_LAST) timeout_cnt <= timeout_cnt + TW'(1);
                    if (edge_hit || timeout_hit) begin
                        trig_ptr   <= wr_ptr;
                        post_cnt   <= (AW+1)'(1);
                        auto_fired <= !edge_hit;
                        if (POST_LAST == '0) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= POST;
                        end
                    end
                end
                POST: if (sample_valid) begin
                    post_cnt <= post_cnt + (AW+1)'(1);
                    if (post_cnt == POST_LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
